// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, RAM data-type codes,
// the default wait limit and the access alignment rule.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      WAIT_MOC = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [1:0] DT_BYTE = 2'b00;
   localparam logic [1:0] DT_HALF = 2'b01;
   localparam logic [1:0] DT_WORD = 2'b10;

   localparam int TIMEOUT_DEFAULT = 15;

   // Reserved size codes count as unusable, so they are rejected like misalignment.
   function automatic logic isMisaligned(input logic [1:0] dt, input logic [7:0] addr);
      logic bad;
      case (dt)
         DT_BYTE: bad = 1'b0;
         DT_HALF: bad = addr[0];
         DT_WORD: bad = (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; the last-grant flop favours the other side
// on a tie and starts out favouring the data port.
module rr_arbiter2 (
   input  logic clk,
   input  logic clr,
   input  logic i_reqData,
   input  logic i_reqFetch,
   input  logic i_take,
   output logic o_grantData,
   output logic o_any
);

   logic r_lastData;

   assign o_any       = i_reqData | i_reqFetch;
   assign o_grantData = i_reqData & (~i_reqFetch | ~r_lastData);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_lastData <= 1'b0;
      end else if (i_take && o_any) begin
         r_lastData <= o_grantData;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single RAM port between instruction fetch and data access through a
// four-state handshake FSM with a bounded wait for the RAM completion strobe.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        if_req,
   input  logic [7:0]  if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [7:0]  d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_dt,
   input  logic        d_sign,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        err,
   output logic        mov,
   output logic        r_w,
   output logic [7:0]  address,
   output logic [31:0] ram_din,
   output logic [1:0]  dt,
   output logic        sign,
   input  logic [31:0] ram_dout,
   input  logic        moc
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic        r_grantData;
   logic [7:0]  r_count;
   logic        w_grantData;
   logic        w_any;
   logic        w_take;

   assign w_take = (r_state == IDLE);

   rr_arbiter2 u_rr (
      .clk         (clk),
      .clr         (clr),
      .i_reqData   (d_req),
      .i_reqFetch  (if_req),
      .i_take      (w_take),
      .o_grantData (w_grantData),
      .o_any       (w_any)
   );

   // The RAM-side controls are latched at grant, so requester inputs may change
   // (even illegally drop) without disturbing the access in flight.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state     <= IDLE;
         r_grantData <= 1'b0;
         r_count     <= 8'd0;
         mov         <= 1'b0;
         r_w         <= 1'b1;
         address     <= 8'd0;
         ram_din     <= 32'd0;
         dt          <= DT_BYTE;
         sign        <= 1'b0;
         if_ack      <= 1'b0;
         d_ack       <= 1'b0;
         err         <= 1'b0;
         if_rdata    <= 32'd0;
         d_rdata     <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state     <= SETUP;
                  r_grantData <= w_grantData;
                  r_count     <= 8'd0;
                  if (w_grantData) begin
                     r_w     <= d_rw;
                     address <= d_addr;
                     ram_din <= d_wdata;
                     dt      <= d_dt;
                     sign    <= d_sign;
                  end else begin
                     r_w     <= 1'b1;
                     address <= if_addr;
                     ram_din <= 32'd0;
                     dt      <= DT_WORD;
                     sign    <= 1'b0;
                  end
               end
            end
            SETUP: begin
               if (r_grantData && isMisaligned(dt, address)) begin
                  r_state <= DONE;
                  d_ack   <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  r_state <= WAIT_MOC;
                  mov     <= 1'b1;
                  r_count <= 8'd0;
               end
            end
            WAIT_MOC: begin
               if (moc) begin
                  r_state <= DONE;
                  mov     <= 1'b0;
                  err     <= 1'b0;
                  if (r_grantData) begin
                     d_ack <= 1'b1;
                     if (r_w) d_rdata <= ram_dout;
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= ram_dout;
                  end
               end else if (r_count == LAST_WAIT) begin
                  r_state <= DONE;
                  mov     <= 1'b0;
                  err     <= 1'b1;
                  if (r_grantData) d_ack <= 1'b1;
                  else             if_ack <= 1'b1;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               if_ack  <= 1'b0;
               d_ack   <= 1'b0;
               err     <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the RAM side (moc, ram_dout) is driven by hand
// and every expected value below is worked out from the handshake timing.
module tb_mem_arbiter;

   logic        clk;
   logic        clr;
   logic        if_req;
   logic [7:0]  if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_rw;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_dt;
   logic        d_sign;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        err;
   logic        mov;
   logic        r_w;
   logic [7:0]  address;
   logic [31:0] ram_din;
   logic [1:0]  dt;
   logic        sign;
   logic [31:0] ram_dout;
   logic        moc;

   int totalCount;
   int badCount;

   mem_arbiter dut (
      .clk      (clk),
      .clr      (clr),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ack   (if_ack),
      .d_req    (d_req),
      .d_rw     (d_rw),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_dt     (d_dt),
      .d_sign   (d_sign),
      .d_rdata  (d_rdata),
      .d_ack    (d_ack),
      .err      (err),
      .mov      (mov),
      .r_w      (r_w),
      .address  (address),
      .ram_din  (ram_din),
      .dt       (dt),
      .sign     (sign),
      .ram_dout (ram_dout),
      .moc      (moc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) else begin
         badCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      totalCount = 0;
      badCount   = 0;
      clr      = 1'b1;
      if_req   = 1'b0;
      if_addr  = 8'h00;
      d_req    = 1'b0;
      d_rw     = 1'b1;
      d_addr   = 8'h00;
      d_wdata  = 32'h0;
      d_dt     = 2'b10;
      d_sign   = 1'b0;
      ram_dout = 32'h0;
      moc      = 1'b0;

      // Reset values while clr is held.
      #1;
      checkOutput("rst_mov",     32'(mov),     32'h0);
      checkOutput("rst_rw",      32'(r_w),     32'h1);
      checkOutput("rst_address", 32'(address), 32'h0);
      checkOutput("rst_acks",    32'({if_ack, d_ack, err}), 32'h0);
      checkOutput("rst_dt",      32'(dt),      32'h0);
      @(posedge clk);
      #1 clr = 1'b0;

      // Fetch with moc already high: moc outside WAIT_MOC must be ignored.
      if_req   = 1'b1;
      if_addr  = 8'h10;
      ram_dout = 32'hE3A01005;
      moc      = 1'b1;
      applyStimulus(1);
      checkOutput("f_setup_mov",  32'(mov),     32'h0);
      checkOutput("f_setup_addr", 32'(address), 32'h10);
      checkOutput("f_setup_rwdt", 32'({r_w, dt, sign}), 32'b1100);
      checkOutput("f_setup_ack",  32'(if_ack),  32'h0);
      applyStimulus(1);
      checkOutput("f_wait_mov",   32'(mov),     32'h1);
      applyStimulus(1);
      checkOutput("f_done_ack",   32'(if_ack),  32'h1);
      checkOutput("f_done_dack",  32'(d_ack),   32'h0);
      checkOutput("f_done_err",   32'(err),     32'h0);
      checkOutput("f_done_mov",   32'(mov),     32'h0);
      checkOutput("f_rdata",      if_rdata,     32'hE3A01005);
      if_req = 1'b0;
      applyStimulus(1);
      checkOutput("f_idle_ack",   32'(if_ack),  32'h0);

      // Simultaneous requests twice: data, fetch, data, fetch.
      if_req   = 1'b1;
      if_addr  = 8'h08;
      d_req    = 1'b1;
      d_rw     = 1'b1;
      d_addr   = 8'h04;
      d_dt     = 2'b10;
      ram_dout = 32'h11223344;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1);
         checkOutput("rr_data_addr", 32'(address), 32'h04);
         applyStimulus(2);
         checkOutput("rr_data_ack",  32'({if_ack, d_ack}), 32'b01);
         checkOutput("rr_data_rd",   d_rdata, 32'h11223344);
         d_req = 1'b0;
         applyStimulus(2);
         checkOutput("rr_fetch_addr", 32'(address), 32'h08);
         applyStimulus(2);
         checkOutput("rr_fetch_ack", 32'({if_ack, d_ack}), 32'b10);
         d_req = (i == 0);
         applyStimulus(1);
      end
      if_req = 1'b0;
      moc    = 1'b0;

      // Word write, moc arriving on the 4th WAIT_MOC cycle.
      d_req   = 1'b1;
      d_rw    = 1'b0;
      d_addr  = 8'h20;
      d_dt    = 2'b10;
      d_wdata = 32'hDEADBEEF;
      applyStimulus(1);
      checkOutput("w_setup_din", ram_din,     32'hDEADBEEF);
      checkOutput("w_setup_rw",  32'(r_w),    32'h0);
      checkOutput("w_setup_adr", 32'(address), 32'h20);
      applyStimulus(1);
      checkOutput("w_wait1_mov", 32'(mov),    32'h1);
      applyStimulus(2);
      checkOutput("w_wait3_mov", 32'(mov),    32'h1);
      checkOutput("w_wait3_rw",  32'(r_w),    32'h0);
      checkOutput("w_wait3_ack", 32'(d_ack),  32'h0);
      applyStimulus(1);
      moc = 1'b1;
      applyStimulus(1);
      checkOutput("w_done_ack",  32'(d_ack),  32'h1);
      checkOutput("w_done_err",  32'(err),    32'h0);
      checkOutput("w_done_rw",   32'(r_w),    32'h0);
      checkOutput("w_done_din",  ram_din,     32'hDEADBEEF);
      checkOutput("w_no_rdata",  d_rdata,     32'h11223344);
      d_req = 1'b0;
      moc   = 1'b0;
      applyStimulus(1);

      // Timeout: moc never comes, abort after 15 WAIT_MOC cycles.
      d_req    = 1'b1;
      d_rw     = 1'b1;
      d_addr   = 8'h30;
      ram_dout = 32'hCAFEF00D;
      applyStimulus(2);
      checkOutput("to_wait1_mov",  32'(mov),   32'h1);
      applyStimulus(14);
      checkOutput("to_wait15_mov", 32'(mov),   32'h1);
      checkOutput("to_wait15_ack", 32'(d_ack), 32'h0);
      applyStimulus(1);
      checkOutput("to_done_ack",   32'(d_ack), 32'h1);
      checkOutput("to_done_err",   32'(err),   32'h1);
      checkOutput("to_done_mov",   32'(mov),   32'h0);
      checkOutput("to_rdata_kept", d_rdata,    32'h11223344);
      d_req = 1'b0;
      applyStimulus(1);
      checkOutput("to_idle_err",   32'({d_ack, err}), 32'h0);

      // Misaligned word and reserved size both skip the RAM.
      moc    = 1'b1;
      d_req  = 1'b1;
      d_addr = 8'h22;
      d_dt   = 2'b10;
      applyStimulus(1);
      checkOutput("mis_setup_mov", 32'(mov),   32'h0);
      applyStimulus(1);
      checkOutput("mis_done",      32'({d_ack, err, mov}), 32'b110);
      d_req = 1'b0;
      applyStimulus(1);
      d_req  = 1'b1;
      d_addr = 8'h40;
      d_dt   = 2'b11;
      applyStimulus(2);
      checkOutput("rsv_done",      32'({d_ack, err, mov}), 32'b110);
      d_req = 1'b0;
      moc   = 1'b0;
      applyStimulus(1);

      // clr in the middle of a data read; afterwards data must win a tie again.
      d_req  = 1'b1;
      d_rw   = 1'b1;
      d_addr = 8'h44;
      d_dt   = 2'b10;
      applyStimulus(2);
      checkOutput("clr_pre_mov", 32'(mov), 32'h1);
      #2 clr = 1'b1;
      #1;
      checkOutput("clr_mov",     32'(mov),     32'h0);
      checkOutput("clr_rw",      32'(r_w),     32'h1);
      checkOutput("clr_address", 32'(address), 32'h0);
      checkOutput("clr_rdata",   d_rdata,      32'h0);
      checkOutput("clr_ifrdata", if_rdata,     32'h0);
      checkOutput("clr_dt",      32'(dt),      32'h0);
      @(posedge clk);
      #1 clr = 1'b0;
      d_req = 1'b0;
      applyStimulus(2);
      checkOutput("clr_no_ack",  32'({if_ack, d_ack, mov}), 32'h0);

      if_req   = 1'b1;
      if_addr  = 8'h60;
      d_req    = 1'b1;
      d_addr   = 8'h50;
      moc      = 1'b1;
      ram_dout = 32'h0000ABCD;
      applyStimulus(1);
      checkOutput("post_clr_grant", 32'(address), 32'h50);
      applyStimulus(2);
      checkOutput("post_clr_ack",   32'({if_ack, d_ack, err}), 32'b010);
      checkOutput("post_clr_rdata", d_rdata, 32'h0000ABCD);
      if_req = 1'b0;
      d_req  = 1'b0;
      moc    = 1'b0;
      applyStimulus(2);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of WAIT_MOC cycles before an access is aborted (range 1..255).
REQ-002 Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- clr  in  1  reset, asynchronous, active-high.
- if_req  in  1  instruction-fetch request, level, held until if_ack.
- if_addr  in  8  fetch byte address; fetch is always a word read.
- if_rdata  out  32  fetched word.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, level, held until d_ack.
- d_rw  in  1  1 = read, 0 = write.
- d_addr  in  8  data byte address.
- d_wdata  in  32  write data.
- d_dt  in  2  size: 00 byte, 01 halfword, 10 word, 11 reserved.
- d_sign  in  1  sign-extend byte/halfword reads.
- d_rdata  out  32  data read result.
- d_ack  out  1  one-cycle data completion pulse.
- err  out  1  qualifies the current ack: 1 = access failed.
- mov  out  1  RAM memory-operation-valid strobe.
- r_w  out  1  RAM direction, 1 = read.
- address  out  8  RAM address.
- ram_din  out  32  RAM write data.
- dt  out  2  RAM data type.
- sign  out  1  RAM sign control.
- ram_dout  in  32  RAM read data.
- moc  in  1  RAM memory-operation-complete.

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, WAIT_MOC and DONE.
REQ-004 In IDLE with any request pending, the arbiter SHALL grant at the clock edge and enter SETUP; with no request pending it SHALL stay in IDLE.
REQ-005 When both requests are pending in IDLE, the grant SHALL go to the requester not granted last (round-robin bit, data first after reset); a single pending requester SHALL always win.
REQ-006 At grant, address, r_w, ram_din, dt and sign SHALL be latched from the winner and held stable until DONE exits; for a fetch the values are r_w=1, dt=10, sign=0.
REQ-007 SETUP SHALL last exactly one cycle with mov=0 (address setup), then go to WAIT_MOC.
REQ-008 mov SHALL be 1 only in WAIT_MOC.
REQ-009 In WAIT_MOC, moc sampled 1 SHALL go to DONE with err=0 and, for reads, latch ram_dout into the winner's rdata.
REQ-010 A cycle counter SHALL count WAIT_MOC cycles; when TIMEOUT cycles pass without moc, the FSM SHALL go to DONE with err=1 and rdata unchanged.
REQ-011 DONE SHALL last one cycle and assert exactly one of if_ack or d_ack, plus err; the FSM then returns to IDLE, and the next grant occurs no earlier than the IDLE cycle.
REQ-012 For a data request with d_dt=11, or d_dt=10 with d_addr[1:0]!=0, or d_dt=01 with d_addr[0]!=0, the FSM SHALL skip RAM (mov never asserted) and go from SETUP straight to DONE with err=1.
REQ-013 Minimum latency SHALL be grant edge to ack = 3 cycles (IDLE->SETUP->WAIT_MOC->DONE, with moc=1 on the first WAIT_MOC cycle).
REQ-014 A request deasserted before its ack is a protocol violation; the in-flight access SHALL still complete and ack.
REQ-015 moc sampled outside WAIT_MOC SHALL be ignored.

Reset
REQ-016 clr=1 SHALL immediately force IDLE, mov=0, r_w=1, address=0, ram_din=0, dt=00, sign=0, if_ack=0, d_ack=0, err=0, if_rdata=0, d_rdata=0, counter=0 and round-robin to data-first, including mid-access.

Structure
REQ-017 The state encoding, DT codes (BYTE, HALF, WORD) and the TIMEOUT default SHALL reside in a shared package used by ControlUnit and mem_arbiter.
REQ-018 A sub-module rr_arbiter2 (two-requester round-robin grant with a last-grant flop) SHALL be instantiated; all other logic is flat.

Verification
REQ-019 The bench SHALL cover:
- Fetch if_addr=0x10 with moc on the first WAIT_MOC cycle, ram_dout=0xE3A01005 -> if_ack 3 cycles after grant, if_rdata=0xE3A01005, err=0, mov high for exactly 1 cycle.
- if_req and d_req asserted together twice in succession -> grants data, fetch, data, fetch.
- Data write d_addr=0x20, d_dt=10, d_wdata=0xDEADBEEF, moc after 4 cycles -> ram_din=0xDEADBEEF, r_w=0 held throughout, d_ack=1, err=0.
- moc held low -> after 15 WAIT_MOC cycles d_ack=1, err=1, mov drops.
- d_dt=10 with d_addr=0x22 -> mov never asserted, d_ack=1 with err=1 2 cycles after grant.
- clr pulsed during WAIT_MOC -> all outputs reset at once, no ack, next request served normally.
